status_readback: RTL and testbench

Read-side counterpart of the IO controller's write-only control/interrupt register pair. It latches peripheral events into sticky pending flags. It answers processor reads over the same 2-bit register address space and drives a level interrupt request from the pending flags, masked by the interrupt-enable word that the write side already produces. The block sits between the robot/peripheral logic (event and status sources) and the bus read mux.

---
 rtl/status_readback_if.sv | 24 ++
 rtl/status_readback.sv | 76 +++++++
 tb/tb_status_readback.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/status_readback_if.sv
// Read-side bus bundle for status_readback: read strobe/address, peripheral
// sources and the read response / interrupt outputs.
interface status_readback_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd;
  logic [1:0]            register_addr;
  logic [DATA_WIDTH-1:0] status_in;
  logic [DATA_WIDTH-1:0] event_in;
  logic [DATA_WIDTH-1:0] int_enable;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  irq;

  modport master (
    output rd, register_addr, status_in, event_in, int_enable,
    input  rd_data, rd_valid, irq
  );

  modport slave (
    input  rd, register_addr, status_in, event_in, int_enable,
    output rd_data, rd_valid, irq
  );
endinterface

// File: rtl/status_readback.sv
// Sticky event pending flags, saturating overflow counter and read mux with level irq.
// Latency: read response 1 cycle after rd; irq combinational from registered pending.
// Backpressure: none; one read per cycle, reader must take rd_data while rd_valid.
module status_readback #(
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  status_readback_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] event_prev;
  logic [DATA_WIDTH-1:0] pending, pending_d;
  logic [DATA_WIDTH-1:0] overflow, overflow_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_mux;
  logic [DATA_WIDTH-1:0] evt_edge, clr_mask;
  logic                  clr_pend, clr_ovf, ovf_hit;

  always_comb begin
    evt_edge = bus.event_in & ~event_prev;
    clr_pend = bus.rd && (bus.register_addr == 2'b11);
    clr_ovf  = bus.rd && (bus.register_addr == 2'b10);
    clr_mask = {DATA_WIDTH{clr_pend}};
    // A collision only counts against flags that survive this cycle's clear.
    ovf_hit  = |(evt_edge & pending & ~clr_mask);
    pending_d = (pending & ~clr_mask) | evt_edge;

    overflow_d = overflow;
    if (clr_ovf) begin
      overflow_d = ovf_hit ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : '0;
    end else if (ovf_hit && (overflow != {DATA_WIDTH{1'b1}})) begin
      overflow_d = overflow + 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.register_addr)
      2'b00:   rd_mux = bus.status_in;
      2'b01:   rd_mux = pending;
      2'b10:   rd_mux = overflow;
      default: rd_mux = pending;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.rd) state_d = RESP;
      RESP:    if (!bus.rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      event_prev <= '0;
      pending    <= '0;
      overflow   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      event_prev <= bus.event_in;
      pending    <= pending_d;
      overflow   <= overflow_d;
      if (bus.rd) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = (state_q == RESP);
  assign bus.irq      = |(pending & bus.int_enable);
endmodule

// File: tb/tb_status_readback.sv
// Bench for status_readback: directed vector table, hand sequences, and a
// randomized phase against a rule-level reference model; 4-bit build for saturation.
module tb_status_readback;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  status_readback_if #(.DATA_WIDTH(32)) bus ();
  status_readback_if #(.DATA_WIDTH(4))  bus4 ();

  status_readback #(.DATA_WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  status_readback #(.DATA_WIDTH(4))  dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending set of bits, count of collision cycles, last response.
  logic [31:0] m_pend = '0, m_prev = '0, m_ovf = '0, m_data = '0;
  bit          m_vld = 1'b0;
  logic [31:0] m_rise;
  bit          m_clr, m_coll;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_ovf = '0; m_data = '0; m_vld = 1'b0;
    end else begin
      m_rise = bus.event_in & ~m_prev;
      m_prev = bus.event_in;
      m_clr  = bus.rd && bus.register_addr == 2'd3;
      m_coll = !m_clr && ((m_rise & m_pend) != 0);
      m_vld  = bus.rd;
      if (bus.rd) begin
        case (bus.register_addr)
          2'd0: m_data = bus.status_in;
          2'd2: m_data = m_ovf;
          default: m_data = m_pend;
        endcase
      end
      if (bus.rd && bus.register_addr == 2'd2) m_ovf = m_coll ? 32'd1 : 32'd0;
      else if (m_coll && m_ovf < 32'hFFFF_FFFF) m_ovf = m_ovf + 32'd1;
      if (m_clr) m_pend = '0;
      m_pend = m_pend | m_rise;
    end
  end

  typedef struct {
    bit          rst;
    bit          rd;
    bit [1:0]    addr;
    logic [31:0] status;
    logic [31:0] evt;
    logic [31:0] en;
    bit          exp_vld;
    logic [31:0] exp_data;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit rd, input bit [1:0] a, input logic [31:0] st,
                     input logic [31:0] ev, input logic [31:0] en, input bit v,
                     input logic [31:0] d, input bit irq);
    vec_t x;
    x.rst = r; x.rd = rd; x.addr = a; x.status = st; x.evt = ev; x.en = en;
    x.exp_vld = v; x.exp_data = d; x.exp_irq = irq;
    vecs.push_back(x);
  endtask

  task automatic tick4();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rd = 1'b0; bus.register_addr = 2'd0; bus.status_in = '0;
    bus.event_in = '0; bus.int_enable = '0;
    bus4.rd = 1'b0; bus4.register_addr = 2'd0; bus4.status_in = '0;
    bus4.event_in = '0; bus4.int_enable = '0;

    // reset
    add(0,0,0,0,0,0,            0,0,0);
    add(0,0,0,0,0,0,            0,0,0);
    add(1,1,1,0,0,0,            1,0,0);
    // event + irq, clear-read
    add(1,0,0,0,32'h4,32'h4,    0,0,1);
    add(1,1,3,0,0,32'h4,        1,32'h4,0);
    add(1,1,1,0,0,32'h4,        1,0,0);
    // level event held, masked
    for (int i = 0; i < 5; i++) add(1,0,0,0,32'h10,0, 0,0,0);
    add(1,1,2,0,32'h10,0,       1,0,0);
    add(1,0,0,0,0,32'h10,       0,0,1);
    add(1,1,3,0,0,32'h10,       1,32'h10,0);
    // set wins over clear
    add(1,0,0,0,32'h1,32'h10,   0,32'h10,0);
    add(1,1,3,0,32'h2,32'h10,   1,32'h1,0);
    add(1,1,1,0,0,32'h10,       1,32'h2,0);
    // overflow: two collisions
    add(1,0,0,0,32'h1,32'h10,   0,32'h2,0);
    add(1,0,0,0,0,32'h10,       0,32'h2,0);
    add(1,0,0,0,32'h3,32'h10,   0,32'h2,0);
    add(1,0,0,0,0,32'h10,       0,32'h2,0);
    add(1,0,0,0,32'h1,32'h10,   0,32'h2,0);
    add(1,1,2,0,0,32'h10,       1,32'h2,0);
    add(1,1,2,0,0,32'h10,       1,32'h0,0);
    // back-to-back reads
    add(1,1,0,32'hA5A5_0001,0,32'h10, 1,32'hA5A5_0001,0);
    add(1,1,1,0,0,32'h10,       1,32'h3,0);
    add(1,1,3,0,0,32'h10,       1,32'h3,0);
    add(1,0,0,0,0,32'h10,       0,32'h3,0);
    // reset mid-read, event held across reset release
    add(1,1,1,0,0,32'h10,       1,32'h0,0);
    add(0,1,1,0,0,32'h10,       0,32'h0,0);
    add(0,0,0,0,32'h8,32'h8,    0,32'h0,0);
    add(1,0,0,0,32'h8,32'h8,    0,32'h0,1);
    add(1,1,1,0,32'h8,32'h8,    1,32'h8,1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst;
      bus.rd = vecs[i].rd;
      bus.register_addr = vecs[i].addr;
      bus.status_in = vecs[i].status;
      bus.event_in = vecs[i].evt;
      bus.int_enable = vecs[i].en;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rd_valid", i), {31'd0, bus.rd_valid}, {31'd0, vecs[i].exp_vld});
      chk($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
    end

    // int_enable reaches irq without a clock edge
    bus.rd = 1'b0;
    bus.int_enable = 32'h0;
    #1;
    chk("irq_mask_same_cycle", {31'd0, bus.irq}, 32'd0);
    bus.int_enable = 32'h8;
    #1;
    chk("irq_unmask_same_cycle", {31'd0, bus.irq}, 32'd1);

    // saturation on the 4-bit build
    rst4_n = 1'b0;
    tick4(); tick4();
    rst4_n = 1'b1;
    bus4.event_in = 4'h1; tick4();
    bus4.event_in = 4'h0; tick4();
    for (int i = 0; i < 20; i++) begin
      bus4.event_in = 4'h1; tick4();
      bus4.event_in = 4'h0; tick4();
    end
    bus4.rd = 1'b1; bus4.register_addr = 2'd2; tick4();
    chk("sat4 count", {28'd0, bus4.rd_data}, 32'hF);
    chk("sat4 valid", {31'd0, bus4.rd_valid}, 32'd1);
    tick4();
    chk("sat4 cleared", {28'd0, bus4.rd_data}, 32'h0);
    bus4.rd = 1'b0; tick4();
    chk("sat4 idle", {31'd0, bus4.rd_valid}, 32'd0);

    // randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      bus.rd = $urandom_range(0, 1);
      bus.register_addr = 2'($urandom_range(0, 3));
      bus.status_in = $urandom;
      bus.event_in = ($urandom & 32'h0000_000F) | (($urandom_range(0, 7) == 0) ? $urandom : 32'h0);
      bus.int_enable = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d rd_valid", i), {31'd0, bus.rd_valid}, {31'd0, m_vld});
      chk($sformatf("rnd%0d rd_data", i), bus.rd_data, m_data);
      chk($sformatf("rnd%0d irq", i), {31'd0, bus.irq}, {31'd0, |(m_pend & bus.int_enable)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
